// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM encoding and arithmetic helpers for the serial FIR
package fir_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic signed [63:0] sat_round(input logic signed [127:0] acc, input int shift, input int dw, output logic sat);
    logic signed [127:0] r, mx, mn;
    r = (acc + (128'sd1 <<< (shift - 1))) >>> shift;
    mx = (128'sd1 <<< (dw - 1)) - 128'sd1;
    mn = -(128'sd1 <<< (dw - 1));
    sat = r > mx || r < mn;
    return r > mx ? mx[63:0] : r < mn ? mn[63:0] : r[63:0];
  endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered signed multiply-accumulate with clear and enable
module fir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [DATA_W+COEF_W-1:0] p;
  assign p = a * b;
  always_ff @(posedge clk) begin
    acc <= rst || clr ? '0 : en ? acc + {{(ACC_W-DATA_W-COEF_W){p[DATA_W+COEF_W-1]}}, p} : acc;
  end
endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR filter sharing one multiplier across all taps
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS = 32,
  parameter int OUT_SHIFT = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic signed [DATA_W-1:0]        in_data,
  output logic                            in_ready,
  input  logic                            coef_we,
  input  logic [fir_pkg::clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]        coef_data,
  output logic                            out_valid,
  output logic signed [DATA_W-1:0]        out_data,
  output logic                            out_sat
);
  localparam int ACC_W = DATA_W + COEF_W + clog2(NTAPS);
  localparam int AW = clog2(NTAPS);
  state_t state, state_d;
  logic signed [DATA_W-1:0] hist [NTAPS];
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic [AW-1:0] wr_ptr, rd_ptr, tap;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_W-1:0] out_d;
  logic accept, sat_d;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  fir_mac_unit #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(state == MAC),
    .a(hist[rd_ptr]),
    .b(coef[tap]),
    .acc(acc)
  );
  always_comb begin
    sat_d = 1'b0;
    state_d = state == IDLE ? (in_valid ? MAC : IDLE) : state == MAC ? (int'(tap) == NTAPS - 1 ? OUT : MAC) : IDLE;
    out_d = DATA_W'(sat_round({{(128-ACC_W){acc[ACC_W-1]}}, acc}, OUT_SHIFT, DATA_W, sat_d));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tap <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      state <= state_d;
      out_valid <= state == OUT;
      if (state == IDLE && coef_we && {1'b0, coef_addr} < (AW+1)'(NTAPS)) coef[coef_addr] <= coef_data;
      if (accept) begin
        hist[wr_ptr] <= in_data;
        rd_ptr <= wr_ptr;
        tap <= '0;
      end
      if (state == MAC) begin
        rd_ptr <= rd_ptr == '0 ? AW'(NTAPS - 1) : rd_ptr - 1'b1;
        tap <= tap + 1'b1;
      end
      if (state == OUT) begin
        out_data <= out_d;
        out_sat <= sat_d;
        wr_ptr <= int'(wr_ptr) == NTAPS - 1 ? '0 : wr_ptr + 1'b1;
      end
    end
  end
endmodule
